// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART (transmitter and receiver).
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Counter width for a bit period; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-FF synchronizer, mid-bit sampling FSM, rx_data/rx_ready.
// Optional rx_frame_err pulse when UART_FRAME_ERR_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1042
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready
`ifdef UART_FRAME_ERR_EN
    ,
    output logic                 rx_frame_err
`endif
);

    localparam int unsigned     CNT_W     = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

    logic rx_meta;
    logic rx_sync;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [BIT_IDX_W-1:0] idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 armed, armed_n;
    logic [DATA_BITS-1:0] rx_data_n;
    logic                 rx_ready_n;
`ifdef UART_FRAME_ERR_EN
    logic                 rx_frame_err_n;
`endif

    // Metastability guard; resets to the idle line level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            armed    <= 1'b0;
            rx_data  <= '0;
            rx_ready <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            shift    <= shift_n;
            armed    <= armed_n;
            rx_data  <= rx_data_n;
            rx_ready <= rx_ready_n;
        end
    end

`ifdef UART_FRAME_ERR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= rx_frame_err_n;
        end
    end
`endif

    // 'armed' stays low after a bad stop bit so a held-low line (break) cannot restart reception.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        idx_n      = idx;
        shift_n    = shift;
        armed_n    = armed;
        rx_data_n  = rx_data;
        rx_ready_n = 1'b0;
`ifdef UART_FRAME_ERR_EN
        rx_frame_err_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (rx_sync) begin
                    armed_n = 1'b1;
                end else if (armed) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n   = '0;
                    state_n = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shift_n = {rx_sync, shift[DATA_BITS-1:1]};
                    if (idx == IDX_LAST) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_sync) begin
                        rx_data_n  = shift;
                        rx_ready_n = 1'b1;
                    end else begin
                        armed_n = 1'b0;
`ifdef UART_FRAME_ERR_EN
                        rx_frame_err_n = 1'b1;
`endif
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 UART top: inline transmitter FSM plus the uart_rx receiver.
// Define UART_FRAME_ERR_EN to expose the rx_frame_err pulse output.
module uart
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1042
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    input  logic                 rx,
    output logic                 tx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    output logic                 tx_busy
`ifdef UART_FRAME_ERR_EN
    ,
    output logic                 rx_frame_err
`endif
);

    localparam int unsigned      CNT_W    = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] IDX_LAST = BIT_IDX_W'(DATA_BITS - 1);

    state_t               tx_state, tx_state_n;
    logic [CNT_W-1:0]     tx_cnt, tx_cnt_n;
    logic [BIT_IDX_W-1:0] tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
    logic                 tx_n;
    logic                 tx_busy_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx       <= tx_n;
            tx_busy  <= tx_busy_n;
        end
    end

    // Line level is computed one cycle ahead so each bit appears registered on the pin.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_n       = tx;
        tx_busy_n  = tx_busy;
        case (tx_state)
            IDLE: begin
                tx_n      = 1'b1;
                tx_busy_n = 1'b0;
                tx_cnt_n  = '0;
                tx_idx_n  = '0;
                if (tx_start) begin
                    tx_shift_n = tx_data;
                    tx_n       = 1'b0;
                    tx_busy_n  = 1'b1;
                    tx_state_n = START;
                end
            end
            START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_n       = tx_shift[0];
                    tx_state_n = DATA;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == IDX_LAST) begin
                        tx_n       = 1'b1;
                        tx_state_n = STOP;
                    end else begin
                        tx_shift_n = tx_shift >> 1;
                        tx_n       = tx_shift[1];
                        tx_idx_n   = tx_idx + 1'b1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_n       = 1'b1;
                    tx_busy_n  = 1'b0;
                    tx_state_n = IDLE;
                end else begin
                    tx_cnt_n = tx_cnt + 1'b1;
                end
            end
            default: begin
                tx_n       = 1'b1;
                tx_busy_n  = 1'b0;
                tx_state_n = IDLE;
            end
        endcase
    end

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready)
`ifdef UART_FRAME_ERR_EN
        ,
        .rx_frame_err(rx_frame_err)
`endif
    );

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: directed steps with random bytes, frame-level reference model.
module tb_uart;

    localparam int unsigned C = 16;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_start = 1'b0;
    logic       rx       = 1'b1;
    logic       tx;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_busy;
`ifdef UART_FRAME_ERR_EN
    logic       rx_frame_err;
    int         ferr_seen = 0;
    int         ferr_exp  = 0;
`endif

    int         checks = 0;
    int         passed = 0;
    int         failed = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic [7:0] b;

    always #5 clk = ~clk;

    uart #(
        .CLKS_PER_BIT(C)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_start(tx_start),
        .rx      (rx),
        .tx      (tx),
        .rx_data (rx_data),
        .rx_ready(rx_ready),
        .tx_busy (tx_busy)
`ifdef UART_FRAME_ERR_EN
        ,
        .rx_frame_err(rx_frame_err)
`endif
    );

    // Every cycle with rx_ready high delivers one byte.
    always @(posedge clk) begin
        if (rx_ready === 1'b1) got_q.push_back(rx_data);
`ifdef UART_FRAME_ERR_EN
        if (rx_frame_err === 1'b1) ferr_seen++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one byte and compares the pin against the ideal 10-bit frame, cycle by cycle.
    task automatic tx_frame(input logic [7:0] d, input int inject_at, input logic [7:0] inj);
        logic [9:0] exp_f;
        logic [9:0] obs_f;
        int         busy_cnt;
        exp_f    = {1'b1, d, 1'b0};
        obs_f    = exp_f;
        busy_cnt = 0;
        tx_data  = d;
        tx_start = 1'b1;
        for (int i = 0; i < 10 * C; i++) begin
            @(negedge clk);
            if (i == 0) begin
                tx_start = 1'b0;
                tx_data  = 8'($urandom);
            end
            if (tx !== exp_f[i / C]) obs_f[i / C] = tx;
            if (tx_busy === 1'b1) busy_cnt++;
            if (i == inject_at) begin
                tx_start = 1'b1;
                tx_data  = inj;
            end else if (i == inject_at + 1) begin
                tx_start = 1'b0;
            end
        end
        tx_start = 1'b0;
        @(negedge clk);
        chk("tx_frame_bits", 32'(obs_f), 32'(exp_f));
        chk("tx_busy_cycles", busy_cnt, 10 * C);
        chk("tx_busy_end", tx_busy, 1'b0);
        chk("tx_idle_high", tx, 1'b1);
    endtask

    task automatic rx_drive(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = d[k];
            repeat (C) @(negedge clk);
        end
        rx = stop;
        repeat (C) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        rx_drive(d, stop);
        if (stop) begin
            exp_q.push_back(d);
            last_good = d;
        end
`ifdef UART_FRAME_ERR_EN
        else ferr_exp++;
`endif
    endtask

    task automatic rx_check(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
        chk({tag, "_hold"}, rx_data, last_good);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_ready", rx_ready, 1'b0);
`ifdef UART_FRAME_ERR_EN
        chk("rst_frame_err", rx_frame_err, 1'b0);
`endif
        reset = 1'b1;

        // Fixed pattern, then random bytes back to back
        tx_frame(8'hA5, -1, 8'h00);
        repeat (4) tx_frame(8'($urandom), -1, 8'h00);

        // tx_start during a frame must not disturb it
        tx_frame(8'($urandom), C + 3, 8'h3C);
        tx_frame(8'($urandom), int'($urandom_range(2 * C, 9 * C)), 8'h3C);

        rx_frame(8'h55, 1'b1);
        rx_check("rx_55");
        repeat (4) rx_frame(8'($urandom), 1'b1);
        rx_check("rx_rand");

        // Bad stop bit: byte dropped, rx_data keeps the previous good byte
        b = 8'($urandom);
        if (b == 8'h55) b = 8'hAA;
        rx_frame(b, 1'b1);
        rx_frame(8'h55, 1'b0);
        rx_check("rx_ferr");

        // Break: line held low for three frame times
        rx = 1'b0;
        repeat (30 * C) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
`ifdef UART_FRAME_ERR_EN
        ferr_exp++;
`endif
        rx_check("rx_break");
        rx_frame(8'($urandom), 1'b1);
        rx_check("rx_after_break");

        // Short low glitch is not a start bit
        rx = 1'b0;
        repeat (C / 4) @(negedge clk);
        rx = 1'b1;
        repeat (2 * C) @(negedge clk);
        rx_check("rx_glitch");
        rx_frame(8'($urandom), 1'b1);
        rx_check("rx_after_glitch");

        // Both directions at once
        fork
            tx_frame(8'($urandom), -1, 8'h00);
            rx_frame(8'($urandom), 1'b1);
        join
        rx_check("duplex");

        // Reset during TX data bit 3 with an RX frame in flight; tail bits are all ones
        b = {4'hF, 4'($urandom)};
        fork
            rx_drive(b, 1'b1);
            begin
                tx_data  = 8'($urandom);
                tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                repeat (4 * C + C / 2 - 1) @(negedge clk);
                reset = 1'b0;
                #1;
                chk("mid_rst_tx", tx, 1'b1);
                chk("mid_rst_busy", tx_busy, 1'b0);
                chk("mid_rst_rx_data", rx_data, 8'h00);
                repeat (C / 2 + 4) @(negedge clk);
                reset = 1'b1;
            end
        join
        last_good = 8'h00;
        rx_check("rst_rx_lost");
        tx_frame(8'($urandom), -1, 8'h00);
        rx_frame(8'($urandom), 1'b1);
        rx_check("rst_rx_clean");

`ifdef UART_FRAME_ERR_EN
        chk("frame_err_pulses", ferr_seen, ferr_exp);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
